exp_collect: RTL and testbench
==============================

# exp_collect

Result-collection stage directly downstream of the `exp` pipeline. It captures every sample the exponential unit emits on its `write_enable` strobe into a first-word-fall-through FIFO and presents the samples to the RISC-V side through a valid/ready handshake. It also keeps a saturating running sum of accepted samples (softmax/normalisation denominator), an occupancy count and a sticky overflow flag.

## Interface
- `DATA_W`, 16, sample width; matches `exp` `output_data`.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `SUM_W`, 32, running-sum width; must be > `DATA_W`.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `data_in`  in  DATA_W  sample from `exp` `output_data`.
- `write_enable`  in  1  sample strobe from `exp`; one sample per high cycle.
- `clear`  in  1  synchronous flush of FIFO, sum and overflow.
- `out_data`  out  DATA_W  FIFO head; valid only while `out_valid` is high.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `sum`  out  SUM_W  saturating unsigned sum of all accepted samples since reset/clear.
- `overflow`  out  1  sticky; set when a strobed sample is dropped.

## Operation
- Push: `write_enable` high and (not full, or pop in the same cycle). Pop: `out_valid && out_ready`.
- Accepted push: write `data_in` at write pointer, advance pointer (wraps modulo DEPTH), add zero-extended `data_in` to `sum`.
- Sum saturates at 2^SUM_W−1; it never wraps.
- Dropped push (full, no pop): data discarded, `sum` unchanged, `overflow` ← 1.
- Simultaneous push and pop: both performed; `count` unchanged; valid when full (no drop) and when count = 1.
- Pop when empty cannot occur (`out_valid` low); `out_ready` is ignored while empty.
- `clear` has priority over everything in its cycle: pointers, `count`, `sum` and `overflow` → 0; any push or pop in that cycle is ignored and does not set `overflow`.
- `out_data` is combinationally the head entry (FWFT); it holds its value while `out_valid && !out_ready`.
- Occupancy is tracked with pointers one bit wider than the address; full = addresses equal and MSBs differ.

## Timing
- Reset (RST low, asynchronous): `out_valid`=0, `count`=0, `sum`=0, `overflow`=0, pointers 0; `out_data` = 0 (storage cleared).
- Push at edge k into an empty FIFO: `out_valid`=1 and `out_data`=sample after edge k, so a 1-cycle write-to-read latency.
- `count`, `sum` and `overflow` update on the same edge as the push or pop that causes them.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-stream: all contents are lost immediately. The first strobe after RST deasserts is accepted normally.

## Structure
- Shared package `hss_pkg`: `DATA_W` default constant and the sample typedef, shared with `exp`. `SUM_W` default also lives there.
- One sub-module: `sync_fifo`, parameterised on DATA_W/DEPTH, with push/pop/full/empty/count.
- `exp_collect` wraps the FIFO and adds the drop logic, sum accumulator, overflow and clear.

## Test plan
- Reset: RST low mid-run → `out_valid`=0, `count`=0, `sum`=0, `overflow`=0 immediately, without waiting for a clock edge.
- Stream 16'h0200, 16'h0400, 16'h0600, 16'h0800 on consecutive strobes with `out_ready`=0 → `count`=4, `sum`=32'h1400. Then `out_ready`=1 → reads 0200, 0400, 0600, 0800 in order, and `out_valid` drops after the 4th read.
- Fill DEPTH=8 entries, then 2 more strobes with `out_ready`=0 → `count`=8, `overflow`=1, and `sum` excludes the 2 dropped samples.
- With the FIFO full, strobe 16'h0AAA with `out_ready`=1 in the same cycle → head popped, 0AAA accepted, `count` stays 8, `overflow` unchanged.
- Preload `sum` to 2^32−16'h0100, then push 16'hFFFF → `sum`=32'hFFFFFFFF; a further push keeps it saturated.
- `clear` in the same cycle as a strobe while full → `count`=0, `sum`=0, `overflow`=0, strobe not stored; a strobe next cycle gives `count`=1.

Source files
------------

// File: rtl/hss_pkg.sv
// Package: hss_pkg
// Constants and types shared between the exp pipeline and the blocks that
// sit downstream of it.
//   DATA_W_DEF : default sample width (matches exp output_data)
//   SUM_W_DEF  : default running-sum width for normalisation denominators
//   sample_t   : one exp output sample
package hss_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SUM_W_DEF  = 32;

  typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage : hss_pkg

// File: rtl/exp_collect_sync_fifo.sv
// Module: sync_fifo
// Single-clock first-word-fall-through FIFO. rdata always shows the head
// entry; the caller is responsible for only pushing when there is room (or
// popping in the same cycle) and only popping when non-empty.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (clears storage too)
//   clr           : synchronous flush of pointers
//   push, wdata   : write strobe and data
//   pop           : advance head
//   rdata         : head entry (combinational)
//   full, empty   : occupancy flags
//   count         : occupancy 0..DEPTH
module sync_fifo
  import hss_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q[AW-1:0]] = wdata;
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign count = wptr_q - rptr_q;

endmodule : sync_fifo

// File: rtl/exp_collect.sv
// Module: exp_collect
// Collects every sample strobed out of the exp unit into a FWFT FIFO and
// hands it to the consumer over valid/ready. Also keeps a saturating sum of
// accepted samples and a sticky flag for samples dropped on a full FIFO.
// Ports:
//   CLK, RST      : clock, asynchronous active-low reset
//   data_in       : sample from exp
//   write_enable  : sample strobe, one sample per high cycle
//   clear         : synchronous flush of FIFO, sum and overflow
//   out_data      : FIFO head, meaningful while out_valid
//   out_valid     : FIFO non-empty
//   out_ready     : consumer takes the head this cycle
//   count         : occupancy 0..DEPTH
//   sum           : saturating sum of accepted samples
//   overflow      : sticky, a strobed sample was dropped
module exp_collect
  import hss_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     write_enable,
  input  logic                     clear,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [SUM_W-1:0]         sum,
  output logic                     overflow
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             overflow_q, overflow_d;

  // Clear suppresses both sides of the handshake in its cycle.
  assign pop  = !fifo_empty && out_ready && !clear;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = write_enable && (!fifo_full || pop) && !clear;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (clear),
    .push  (push),
    .wdata (data_in),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // One guard bit catches the carry out; on carry the sum pins to all ones.
  assign sum_wide = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, data_in};

  always_comb begin
    sum_d      = sum_q;
    overflow_d = overflow_q;
    if (clear) begin
      sum_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        sum_d = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
      end
      if (write_enable && !push) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign sum       = sum_q;
  assign overflow  = overflow_q;

endmodule : exp_collect

// File: tb/tb_exp_collect.sv
module tb_exp_collect;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] data_in = '0;
  logic        write_enable = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  count;
  logic [31:0] sum;
  logic        overflow;

  // Second instance with a narrow sum to reach saturation in few cycles.
  logic [15:0] data_in2 = '0;
  logic        write_enable2 = 1'b0;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic [3:0]  count2;
  logic [16:0] sum2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  exp_collect #(.DATA_W(16), .DEPTH(8), .SUM_W(32)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .write_enable(write_enable),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .sum(sum), .overflow(overflow)
  );

  exp_collect #(.DATA_W(16), .DEPTH(8), .SUM_W(17)) dut_sat (
    .CLK(CLK), .RST(RST), .data_in(data_in2), .write_enable(write_enable2),
    .clear(1'b0), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(1'b1), .count(count2), .sum(sum2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] vals [4];

  initial begin
    vals[0] = 16'h0200; vals[1] = 16'h0400; vals[2] = 16'h0600; vals[3] = 16'h0800;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    tick();
    RST = 1'b1;
    tick();

    // Stream four samples with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      write_enable = 1'b1; data_in = vals[i];
      tick();
      if (i == 0) begin
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {16'd0, out_data}, 32'h0200);
      end
    end
    write_enable = 1'b0;
    chk("stream_count", {28'd0, count}, 32'd4);
    chk("stream_sum", sum, 32'h1400);
    tick();
    chk("stall_hold", {16'd0, out_data}, 32'h0200);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("read%0d", i), {16'd0, out_data}, {16'd0, vals[i]});
      tick();
    end
    out_ready = 1'b0;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {28'd0, count}, 32'd0);
    chk("drain_sum", sum, 32'h1400);

    // Fill, then two drops
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_sum", sum, 32'd0);
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1; data_in = 16'(16 * (i + 1));
      tick();
    end
    chk("full_ovf0", {31'd0, overflow}, 32'd0);
    data_in = 16'h1000; tick();
    data_in = 16'h2000; tick();
    write_enable = 1'b0;
    chk("full_count", {28'd0, count}, 32'd8);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    chk("full_sum", sum, 32'h0240);

    // Push and pop on a full FIFO
    write_enable = 1'b1; data_in = 16'h0AAA; out_ready = 1'b1;
    chk("pp_head", {16'd0, out_data}, 32'h0010);
    tick();
    write_enable = 1'b0; out_ready = 1'b0;
    chk("pp_count", {28'd0, count}, 32'd8);
    chk("pp_ovf", {31'd0, overflow}, 32'd1);
    chk("pp_sum", sum, 32'h0CEA);
    chk("pp_next", {16'd0, out_data}, 32'h0020);

    // Clear wins over a strobe while full
    write_enable = 1'b1; data_in = 16'h5555; clear = 1'b1;
    tick();
    clear = 1'b0; data_in = 16'h0777;
    chk("clr_count", {28'd0, count}, 32'd0);
    chk("clr_sum2", sum, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    tick();
    write_enable = 1'b0;
    chk("post_clr_count", {28'd0, count}, 32'd1);
    chk("post_clr_data", {16'd0, out_data}, 32'h0777);
    chk("post_clr_sum", sum, 32'h0777);

    // Saturation on the 17-bit-sum instance: 0xFFFF + 0xFF01 = 2^17 - 0x100
    write_enable2 = 1'b1; data_in2 = 16'hFFFF; tick();
    data_in2 = 16'hFF01; tick();
    chk("sat_preload", {15'd0, sum2}, 32'h1FF00);
    data_in2 = 16'hFFFF; tick();
    chk("sat_hit", {15'd0, sum2}, 32'h1FFFF);
    data_in2 = 16'h0001; tick();
    write_enable2 = 1'b0;
    chk("sat_hold", {15'd0, sum2}, 32'h1FFFF);
    chk("sat_count", {28'd0, count2}, 32'd1);

    // Asynchronous reset mid-stream, away from a clock edge
    write_enable = 1'b1; data_in = 16'h0333; tick();
    write_enable = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {28'd0, count}, 32'd0);
    chk("arst_sum", sum, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    chk("arst_sum2", {15'd0, sum2}, 32'd0);
    tick();
    RST = 1'b1;
    write_enable = 1'b1; data_in = 16'h0123;
    tick();
    write_enable = 1'b0;
    chk("after_rst_count", {28'd0, count}, 32'd1);
    chk("after_rst_data", {16'd0, out_data}, 32'h0123);
    chk("after_rst_sum", sum, 32'h0123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_exp_collect
